// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch control  |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } hold_entry_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// +----------------------------------------------------------------------------+
// | fetch_hold_buf : one-entry skid register for a response decode refused    |
// | Revision       : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_hold_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_pop,
  input  hold_entry_t i_entry,
  output hold_entry_t o_entry
);

  hold_entry_t r_entry;

  // clear wins over load so a squash in the capture cycle leaves the buffer empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry <= '0;
    end else if (i_clear) begin
      r_entry.valid <= 1'b0;
    end else if (i_load) begin
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_entry.valid <= 1'b0;
    end
  end

  assign o_entry = r_entry;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | fetch_ctrl : PC owner and single-outstanding imem fetch sequencer feeding  |
// |              the IF/ID register. Optional FETCH_PERF_EN adds perf counters|
// | Revision   : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic         w_ld_mem, w_ld_hold, w_squash;
  logic         w_hold_load, w_hold_pop;
  hold_entry_t  w_hold_d, w_hold_q;

  assign w_pc_inc  = r_pc + PC_INC;
  assign w_target  = PCTargetE & ~32'd3;
  assign imem_addr = r_pc;

  always_comb begin
    w_hold_d.instr   = imem_rdata;
    w_hold_d.pc      = r_pc;
    w_hold_d.pcplus4 = w_pc_inc;
    w_hold_d.valid   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ld_mem    = 1'b0;
    w_ld_hold   = 1'b0;
    w_hold_load = 1'b0;
    w_hold_pop  = 1'b0;
    w_squash    = 1'b0;
    imem_req    = (r_state == REQ);

    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ:  if (imem_gnt) w_state_nxt = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          w_pc_nxt = w_pc_inc;
          if (!ValidD || !StallD) begin
            w_ld_mem    = 1'b1;
            w_state_nxt = REQ;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!StallD) begin
          w_hold_pop  = 1'b1;
          w_ld_hold   = w_hold_q.valid;
          w_state_nxt = REQ;
        end
      end
      DROP:    if (imem_rvalid) w_state_nxt = REQ;
      default: w_state_nxt = IDLE;
    endcase

    // a redirect keeps DROP only while a granted response is still in flight
    if (PCSrcE) begin
      w_pc_nxt    = w_target;
      w_squash    = 1'b1;
      w_ld_mem    = 1'b0;
      w_ld_hold   = 1'b0;
      w_hold_load = 1'b0;
      case (r_state)
        REQ:     w_state_nxt = imem_gnt ? DROP : REQ;
        WAIT:    w_state_nxt = imem_rvalid ? REQ : DROP;
        DROP:    w_state_nxt = imem_rvalid ? REQ : DROP;
        default: w_state_nxt = REQ;
      endcase
    end else if (FlushD) begin
      w_squash    = 1'b1;
      w_ld_mem    = 1'b0;
      w_ld_hold   = 1'b0;
      w_hold_load = 1'b0;
    end
  end

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clear (w_squash),
    .i_pop   (w_hold_pop),
    .i_entry (w_hold_d),
    .o_entry (w_hold_q)
  );

  // an unstalled decode with nothing new to take sees a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= '0;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (w_squash) begin
      InstrD   <= NOP_INSTR;
      ValidD   <= 1'b0;
    end else if (w_ld_mem) begin
      InstrD   <= imem_rdata;
      PCD      <= r_pc;
      PCPlus4D <= w_pc_inc;
      ValidD   <= 1'b1;
    end else if (w_ld_hold) begin
      InstrD   <= w_hold_q.instr;
      PCD      <= w_hold_q.pc;
      PCPlus4D <= w_hold_q.pcplus4;
      ValidD   <= 1'b1;
    end else if (!StallD) begin
      ValidD   <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_ld_mem || w_ld_hold)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (!ValidD && (r_state == REQ || r_state == WAIT || r_state == DROP))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

`ifndef SYNTHESIS
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (r_state == WAIT || r_state == DROP || r_state == IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_fetch_ctrl : directed and random checks of fetch_ctrl vs a queue-level |
// |                 reference model                                           |
// | Revision      : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrcE = 1'b0, StallD = 1'b0, FlushD = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

  logic        h_rst = 1'b0, h_gnt = 1'b0, h_rvalid = 1'b0;
  logic [31:0] h_rdata = '0;
  logic        h_req, h_valid;
  logic [31:0] h_addr, h_instr, h_pcd, h_pcp4;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stall, h_perf_fetched, h_perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallD(StallD), .FlushD(FlushD), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(h_rst), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .StallD(1'b0), .FlushD(1'b0), .imem_req(h_req), .imem_addr(h_addr),
    .imem_gnt(h_gnt), .imem_rvalid(h_rvalid), .imem_rdata(h_rdata),
    .InstrD(h_instr), .PCD(h_pcd), .PCPlus4D(h_pcp4), .ValidD(h_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(h_perf_fetched), .perf_stall(h_perf_stall)
`endif
  );

  // reference model: started flag, one outstanding request (maybe stale),
  // a parked flag while decode refuses, a hold slot and the decode slot
  logic        m_live, m_out, m_stale, m_park;
  logic [31:0] m_pc;
  logic        hv;
  logic [31:0] hi, hp;
  logic        dv, dnop;
  logic [31:0] di, dp;

  task automatic model_reset(input logic [31:0] rpc);
    m_live = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_park = 1'b0; m_pc = rpc;
    hv = 1'b0; hi = '0; hp = '0;
    dv = 1'b0; dnop = 1'b0; di = '0; dp = '0;
  endtask

  function automatic logic m_req();
    return m_live && !m_out && !m_park;
  endfunction

  task automatic model_step();
    logic        req, ld;
    logic [31:0] ld_i, ld_p;
    req = m_req();
    ld = 1'b0; ld_i = '0; ld_p = '0;
    if (!m_live) begin
      m_live = 1'b1;
    end else if (req) begin
      if (imem_gnt) begin m_out = 1'b1; m_stale = 1'b0; end
    end else if (m_out) begin
      if (imem_rvalid) begin
        m_out = 1'b0;
        if (!m_stale) begin
          if (!dv || !StallD) begin ld = 1'b1; ld_i = imem_rdata; ld_p = m_pc; end
          else begin hv = 1'b1; hi = imem_rdata; hp = m_pc; m_park = 1'b1; end
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_park && !StallD) begin
      m_park = 1'b0;
      if (hv) begin ld = 1'b1; ld_i = hi; ld_p = hp; hv = 1'b0; end
    end
    if (PCSrcE) begin
      m_pc = {PCTargetE[31:2], 2'b00};
      m_park = 1'b0;
      m_live = 1'b1;
      if (m_out) m_stale = 1'b1;
    end
    if (PCSrcE || FlushD) begin
      dv = 1'b0; di = NOP; dnop = 1'b1; hv = 1'b0;
    end else if (ld) begin
      dv = 1'b1; di = ld_i; dp = ld_p; dnop = 1'b0;
    end else if (!StallD) begin
      dv = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("m_req", 32'(imem_req), 32'(m_req()));
    if (m_req()) chk("m_addr", imem_addr, m_pc);
    chk("m_validd", 32'(ValidD), 32'(dv));
    if (dv || dnop) chk("m_instrd", InstrD, di);
    if (dv) begin
      chk("m_pcd", PCD, dp);
      chk("m_pcplus4d", PCPlus4D, dp + 32'd4);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_instr"}, InstrD, 32'h0);
    chk({tag, "_pcd"}, PCD, 32'h0);
    chk({tag, "_pcp4"}, PCPlus4D, 32'h0);
    chk({tag, "_valid"}, 32'(ValidD), 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    model_reset(32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b1;

    // 1: first fetch, two-cycle latency from grant
    imem_gnt = 1'b1; cyc();
    chk("t1_req", 32'(imem_req), 32'd1);
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; cyc();
    chk("t1_valid", 32'(ValidD), 32'd1);
    chk("t1_instr", InstrD, 32'h0050_0093);
    chk("t1_pcd", PCD, 32'h0);
    chk("t1_pcp4", PCPlus4D, 32'h4);
    chk("t1_next_addr", imem_addr, 32'h4);

    // 2: response under stall goes to the hold buffer
    imem_rvalid = 1'b0; imem_gnt = 1'b1; cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0040_0113; cyc();
    chk("t2_pcd4", PCD, 32'h4);
    StallD = 1'b1; imem_rvalid = 1'b0; imem_gnt = 1'b1; cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0080_0193; cyc();
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk("t2_hold_pcd", PCD, 32'h4);
    chk("t2_hold_instr", InstrD, 32'h0040_0113);
    imem_rvalid = 1'b0; cyc();
    chk("t2_hold_req2", 32'(imem_req), 32'd0);
    StallD = 1'b0; cyc();
    chk("t2_pop_pcd", PCD, 32'h8);
    chk("t2_pop_instr", InstrD, 32'h0080_0193);
    chk("t2_pop_valid", 32'(ValidD), 32'd1);
    chk("t2_next_addr", imem_addr, 32'hC);

    // 3: redirect while waiting drops the stale response
    imem_gnt = 1'b1; cyc();
    imem_gnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h103; cyc();
    chk("t3_drop_req", 32'(imem_req), 32'd0);
    chk("t3_valid", 32'(ValidD), 32'd0);
    chk("t3_nop", InstrD, NOP);
    PCSrcE = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; cyc();
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_nop2", InstrD, NOP);
    imem_rvalid = 1'b0;

    // 4: redirect in the response cycle
    imem_gnt = 1'b1; cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    PCSrcE = 1'b1; PCTargetE = 32'h200; cyc();
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_valid", 32'(ValidD), 32'd0);
    imem_rvalid = 1'b0; PCSrcE = 1'b0;

    // 6: no grant keeps the request stable; async reset mid-WAIT
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_req_hold", 32'(imem_req), 32'd1);
      chk("t6_addr_hold", imem_addr, 32'h200);
    end
    imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset("t6_async");
    model_reset(32'h0);
    @(posedge clk);
    #1 rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    cyc();
    chk("t6_idle_ignore_req", 32'(imem_req), 32'd1);
    chk("t6_idle_ignore_valid", 32'(ValidD), 32'd0);
    imem_rvalid = 1'b0;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      StallD      = ($urandom % 3) == 0;
      FlushD      = ($urandom % 16) == 0;
      PCSrcE      = ($urandom % 20) == 0;
      PCTargetE   = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      imem_gnt    = ($urandom % 2) == 0;
      imem_rvalid = m_out && (($urandom % 5) < 2);
      imem_rdata  = $urandom;
      cyc();
    end
    PCSrcE = 1'b0; FlushD = 1'b0; StallD = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;

    // 5: PC wrap from a high reset vector
    h_rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_req", 32'(h_req), 32'd1);
    chk("t5_addr", h_addr, 32'hFFFF_FFFC);
    h_gnt = 1'b1;
    @(posedge clk); #1;
    h_gnt = 1'b0; h_rvalid = 1'b1; h_rdata = 32'h00A0_0093;
    @(posedge clk); #1;
    h_rvalid = 1'b0;
    chk("t5_valid", 32'(h_valid), 32'd1);
    chk("t5_instr", h_instr, 32'h00A0_0093);
    chk("t5_pcd", h_pcd, 32'hFFFF_FFFC);
    chk("t5_pcp4", h_pcp4, 32'h0);
    chk("t5_next_addr", h_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
